// File: rtl/cardinal_nic.sv
// cardinal_nic: responder end of the processor's NIC port, bridging the
// processor to its ring router port.
//
// The NIC holds two single-entry buffers, each with its own full flag:
//   - input channel  (network -> processor): r_inBuf / r_inFull
//   - output channel (processor -> network): r_outBuf / r_outFull
// The processor polls and moves data through four memory-mapped registers:
//   00 input buffer, 01 input status, 10 output buffer, 11 output status.
// Status registers read as all zeros except bit 63 (the LSB), which holds
// the flag.
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   reset        synchronous, active-low reset
//   addr         register select from the processor
//   d_in         write data from the processor
//   d_out        registered read data to the processor
//   nicEn        access enable from the processor
//   nicWrEn      1 = write, 0 = read (qualified by nicEn)
//   net_si       router offers a packet to the NIC
//   net_ri       NIC can accept a packet (input buffer empty)
//   net_di       packet from the router
//   net_so       NIC injects a packet into the router
//   net_ro       router can accept a packet
//   net_do       packet to the router
//   net_polarity router's current polarity (0 even, 1 odd)
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam logic [0:ADDR_WIDTH-1] ADDR_IN_BUF   = ADDR_WIDTH'(0);
  localparam logic [0:ADDR_WIDTH-1] ADDR_IN_STAT  = ADDR_WIDTH'(1);
  localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_BUF  = ADDR_WIDTH'(2);
  localparam logic [0:ADDR_WIDTH-1] ADDR_OUT_STAT = ADDR_WIDTH'(3);

  logic [0:DATA_WIDTH-1] r_inBuf;
  logic                  r_inFull;
  logic [0:DATA_WIDTH-1] r_outBuf;
  logic                  r_outFull;
  logic [0:DATA_WIDTH-1] r_dOut;

  logic                  w_rdEn;
  logic                  w_wrEn;
  logic                  w_recv;
  logic                  w_send;
  logic [0:DATA_WIDTH-1] w_rdData;

  assign w_rdEn = nicEn & ~nicWrEn;
  assign w_wrEn = nicEn & nicWrEn;

  // Bit 0 of the outgoing packet is its virtual-channel bit; the router only
  // takes a packet whose VC matches its current polarity.
  assign w_send = r_outFull & net_ro & (r_outBuf[0] == net_polarity);
  assign w_recv = net_si & ~r_inFull;

  assign net_ri = ~r_inFull;
  assign net_so = w_send;
  assign net_do = r_outBuf;
  assign d_out  = r_dOut;

  // Read-data selection for the registered processor read port.
  always_comb begin
    w_rdData = '0;
    case (addr)
      ADDR_IN_BUF:   w_rdData = r_inBuf;
      ADDR_IN_STAT:  w_rdData = {{(DATA_WIDTH-1){1'b0}}, r_inFull};
      ADDR_OUT_BUF:  w_rdData = '0;
      ADDR_OUT_STAT: w_rdData = {{(DATA_WIDTH-1){1'b0}}, r_outFull};
      default:       w_rdData = '0;
    endcase
  end

  // Input channel. A capture needs an empty buffer and a read of 00 only
  // clears a full one, so the two can never collide in the same cycle.
  // An offer from the router while full is ignored and the held packet kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inBuf  <= '0;
      r_inFull <= 1'b0;
    end else if (w_recv) begin
      r_inBuf  <= net_di;
      r_inFull <= 1'b1;
    end else if (w_rdEn && (addr == ADDR_IN_BUF)) begin
      r_inFull <= 1'b0;
    end
  end

  // Output channel. Sending only clears the flag; the buffer keeps its last
  // packet so net_do stays stable. A write while full is dropped, which
  // includes the very cycle the buffer drains.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_outBuf  <= '0;
      r_outFull <= 1'b0;
    end else if (w_send) begin
      r_outFull <= 1'b0;
    end else if (w_wrEn && (addr == ADDR_OUT_BUF) && !r_outFull) begin
      r_outBuf  <= d_in;
      r_outFull <= 1'b1;
    end
  end

  // Registered read port: same one-cycle latency as data memory; holds its
  // value whenever there is no read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dOut <= '0;
    end else if (w_rdEn) begin
      r_dOut <= w_rdData;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: directed self-checking bench for cardinal_nic.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// that same point, well away from the active edge.
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int errors = 0;
  int checks = 0;

  cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Processor-side access for the next edge.
  task automatic applyStimulus(input logic en, input logic wr,
                               input logic [1:0] a, input logic [63:0] d);
    nicEn   = en;
    nicWrEn = wr;
    addr    = a;
    d_in    = d;
  endtask

  // Advance one rising edge and settle 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    // Reset held for two edges while a capture and a write are attempted.
    reset        = 1'b0;
    net_si       = 1'b1;
    net_di       = 64'hFFFF_FFFF_FFFF_FFFF;
    net_ro       = 1'b1;
    net_polarity = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_0001);
    tick();
    tick();
    checkOutput("reset_d_out",  d_out,  64'h0);
    checkOutput("reset_net_ri", {63'b0, net_ri}, 64'h1);
    checkOutput("reset_net_so", {63'b0, net_so}, 64'h0);
    checkOutput("reset_net_do", net_do, 64'h0);

    // Receive a packet.
    reset  = 1'b1;
    net_ro = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0);
    net_si = 1'b1;
    net_di = 64'hDEAD_BEEF_0000_0001;
    tick();
    checkOutput("rx_net_ri_low", {63'b0, net_ri}, 64'h0);
    net_si = 1'b0;

    // Poll input status, then read the packet.
    applyStimulus(1'b1, 1'b0, 2'b01, 64'h0);
    tick();
    checkOutput("rx_status_full", d_out, 64'h1);
    applyStimulus(1'b1, 1'b0, 2'b00, 64'h0);
    tick();
    checkOutput("rx_read_data", d_out, 64'hDEAD_BEEF_0000_0001);
    checkOutput("rx_net_ri_high", {63'b0, net_ri}, 64'h1);
    applyStimulus(1'b0, 1'b0, 2'b01, 64'h0);
    tick();
    checkOutput("d_out_hold", d_out, 64'hDEAD_BEEF_0000_0001);
    applyStimulus(1'b1, 1'b0, 2'b01, 64'h0);
    tick();
    checkOutput("rx_status_empty", d_out, 64'h0);
    applyStimulus(1'b1, 1'b0, 2'b10, 64'h0);
    tick();
    checkOutput("read_out_buf_zero", d_out, 64'h0);

    // Send with VC=1 while polarity is even: must wait.
    net_ro       = 1'b1;
    net_polarity = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_00AA);
    tick();
    checkOutput("tx_wrong_pol_so", {63'b0, net_so}, 64'h0);
    checkOutput("tx_net_do", net_do, 64'h8000_0000_0000_00AA);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0);
    tick();
    checkOutput("tx_still_waiting", {63'b0, net_so}, 64'h0);
    net_polarity = 1'b1;
    #1;
    checkOutput("tx_match_pol_so", {63'b0, net_so}, 64'h1);
    tick();
    checkOutput("tx_done_so", {63'b0, net_so}, 64'h0);
    checkOutput("tx_done_do_kept", net_do, 64'h8000_0000_0000_00AA);
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h0);
    tick();
    checkOutput("tx_status_empty", d_out, 64'h0);

    // Back-pressure: second write must be dropped.
    net_ro       = 1'b0;
    net_polarity = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h5);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h7);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h0);
    tick();
    checkOutput("bp_status_full", d_out, 64'h1);
    checkOutput("bp_net_so_low", {63'b0, net_so}, 64'h0);
    net_ro = 1'b1;
    // Write in the same cycle the packet leaves: dropped.
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h9);
    #1;
    checkOutput("bp_send_so", {63'b0, net_so}, 64'h1);
    checkOutput("bp_send_do", net_do, 64'h5);
    tick();
    checkOutput("bp_after_send_so", {63'b0, net_so}, 64'h0);
    checkOutput("bp_drop_in_send_do", net_do, 64'h5);
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h0);
    tick();
    checkOutput("bp_drop_status", d_out, 64'h0);

    // Full input buffer ignores a further offer.
    net_ro = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0);
    net_si = 1'b1;
    net_di = 64'hAAAA_0000_0000_0003;
    tick();
    checkOutput("full_net_ri_low", {63'b0, net_ri}, 64'h0);
    net_di = 64'h2;
    tick();
    net_si = 1'b0;
    // Queue an outgoing packet (VC=0) while the router is busy.
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h10);
    tick();
    // Read 00 in the same cycle the outgoing packet is sent.
    net_ro       = 1'b1;
    net_polarity = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b00, 64'h0);
    #1;
    checkOutput("conc_send_so", {63'b0, net_so}, 64'h1);
    tick();
    checkOutput("full_keeps_first", d_out, 64'hAAAA_0000_0000_0003);
    checkOutput("conc_net_ri_high", {63'b0, net_ri}, 64'h1);
    checkOutput("conc_net_so_low", {63'b0, net_so}, 64'h0);
    checkOutput("conc_net_do", net_do, 64'h10);

    // Mid-operation reset with both buffers full.
    net_ro = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_0001);
    net_si = 1'b1;
    net_di = 64'h44;
    tick();
    net_si = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h0);
    tick();
    checkOutput("pre_rst_out_full", d_out, 64'h1);
    checkOutput("pre_rst_net_ri", {63'b0, net_ri}, 64'h0);
    reset  = 1'b0;
    net_si = 1'b1;
    net_di = 64'h55;
    applyStimulus(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_0003);
    tick();
    reset        = 1'b1;
    net_si       = 1'b0;
    net_ro       = 1'b1;
    net_polarity = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b01, 64'h0);
    #1;
    checkOutput("rst_mid_net_so", {63'b0, net_so}, 64'h0);
    checkOutput("rst_mid_net_ri", {63'b0, net_ri}, 64'h1);
    checkOutput("rst_mid_net_do", net_do, 64'h0);
    checkOutput("rst_mid_d_out", d_out, 64'h0);
    tick();
    checkOutput("rst_mid_in_status", d_out, 64'h0);
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h0);
    tick();
    checkOutput("rst_mid_out_status", d_out, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
